half_adder_sync: RTL and testbench
==================================

# half_adder_sync

Bit-parallel half adder with a combinational result path and a one-cycle registered result path. Each lane computes sum = a XOR b and carry = a AND b. It is the lowest-level arithmetic primitive in the adder hierarchy and is instantiated by full adders and ripple/carry-save structures. The registered path and the optional carry statistics let it sit directly on a clocked pipeline stage.

## Interface
Parameters:
- WIDTH, 1, number of independent 1-bit half-adder lanes (≥1).
- CNT_W, 16, width of the carry statistics counter (≥1).

Ports:
- clk  input  1  clock. One clock domain, all state on its rising edge.
- rst  input  1  reset. Synchronous and active-high.
- a  input  WIDTH  addend A, one bit per lane.
- b  input  WIDTH  addend B, one bit per lane.
- in_valid  input  1  qualifies a and b for the registered path.
- S  output  WIDTH  combinational sum, a ^ b per lane.
- C  output  WIDTH  combinational carry, a & b per lane.
- S_q  output  WIDTH  registered sum.
- C_q  output  WIDTH  registered carry.
- out_valid  output  1  S_q and C_q hold a result captured from a valid cycle.
- carry_cnt  output  CNT_W  count of carry bits seen (see Configuration).

## Operation
- Per lane i: S[i] = a[i] ^ b[i], C[i] = a[i] & b[i]. Lanes are fully independent. There is no carry between lanes.
- Truth table per lane (a,b -> S,C): 00->00, 01->10, 10->10, 11->01.
- S and C are purely combinational. They have no dependence on clk, rst or in_valid.
- Registered path: on a clock edge with in_valid=1, S_q<=S and C_q<=C and out_valid<=1. On an edge with in_valid=0, S_q and C_q hold their values and out_valid<=0.
- X or unknown inputs are not sanitized. Outputs propagate per normal Verilog semantics.

## Timing
- S, C: zero-cycle latency. They are valid within the same delta after a and b settle.
- S_q, C_q, out_valid: one-cycle latency from a sampled in_valid=1 edge.
- Reset (rst=1 at an edge): S_q=0, C_q=0, out_valid=0, carry_cnt=0. Reset takes priority over in_valid in the same cycle.
- Reset mid-stream: the next edge with rst=0 and in_valid=1 produces a normal result one cycle later. No stale data appears.
- Back-to-back valid cycles: a new result every cycle, no bubbles, no backpressure.

## Configuration
- Macro HALF_ADDER_CARRY_CNT_EN.
- Defined: on each edge with in_valid=1 and rst=0, carry_cnt increments by popcount(C) across all lanes. It saturates at 2^CNT_W−1 and never wraps. If the increment would overflow, it clamps to the maximum.
- Undefined: the carry_cnt port still exists and is tied to 0. No counter logic is synthesized.

## Structure
- Shared package half_adder_pkg holds the default WIDTH and CNT_W constants and a lane-result typedef (struct of sum and carry bits).
- Natural sub-module: half_adder_lane, a single-bit combinational cell (a, b -> S, C) instantiated WIDTH times via generate. The registers, valid tracking and counter live in the top.

## Test plan
- WIDTH=1, drive a,b = 00,01,10,11 with 10-unit holds -> S,C = 0 0, 1 0, 1 0, 0 1. The combinational path is correct before any clock edge.
- rst=1 for 2 cycles, then release -> S_q=0, C_q=0, out_valid=0, carry_cnt=0 during and immediately after reset.
- WIDTH=4, in_valid=1, a=4'b1100, b=4'b1010 -> next cycle S_q=4'b0110, C_q=4'b1000, out_valid=1.
- in_valid=0 with changing a,b -> S,C follow the inputs, while S_q and C_q hold the last valid value and out_valid=0.
- HALF_ADDER_CARRY_CNT_EN defined, WIDTH=4, a=b=4'hF for 3 valid cycles -> carry_cnt=12. With CNT_W=3 the counter saturates at 7.
- rst=1 and in_valid=1 in the same cycle with a=b=1 -> C_q=0, out_valid=0, carry_cnt=0.

Source files
------------

// File: rtl/half_adder_pkg.sv
// Shared defaults and the per-lane result type for the half-adder slice.
package half_adder_pkg;

  localparam int DEFAULT_WIDTH = 1;
  localparam int DEFAULT_CNT_W = 16;

  typedef struct packed {
    logic sum;
    logic carry;
  } lane_result_t;

endpackage

// File: rtl/half_adder_sync_lane.sv
// Single-bit combinational half-adder cell.
module half_adder_lane
  import half_adder_pkg::*;
(
  input  logic         a,
  input  logic         b,
  output lane_result_t res
);

  assign res.sum   = a ^ b;
  assign res.carry = a & b;

endmodule

// File: rtl/half_adder_sync.sv
// Bit-parallel half adder with combinational and one-cycle registered outputs.
// Optional saturating carry counter enabled by the HALF_ADDER_CARRY_CNT_EN macro.
module half_adder_sync
  import half_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] S,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] S_q,
  output logic [WIDTH-1:0] C_q,
  output logic             out_valid,
  output logic [CNT_W-1:0] carry_cnt
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
    lane_result_t res;
    half_adder_lane u_lane (
      .a   (a[gi]),
      .b   (b[gi]),
      .res (res)
    );
    assign S[gi] = res.sum;
    assign C[gi] = res.carry;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      S_q       <= '0;
      C_q       <= '0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      S_q       <= S;
      C_q       <= C;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

`ifdef HALF_ADDER_CARRY_CNT_EN
  // One extra bit over the wider of counter and popcount so the sum cannot wrap before clamping.
  localparam int POP_W = $clog2(WIDTH + 1);
  localparam int EXT_W = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;

  logic [EXT_W-1:0] pop_ext;
  logic [EXT_W-1:0] sum_ext;
  logic [EXT_W-1:0] max_ext;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    pop_ext = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop_ext = pop_ext + EXT_W'(C[i]);
    end
  end

  assign max_ext  = EXT_W'({CNT_W{1'b1}});
  assign sum_ext  = EXT_W'(cnt_reg) + pop_ext;
  assign cnt_next = (sum_ext > max_ext) ? {CNT_W{1'b1}} : sum_ext[CNT_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (in_valid) begin
      cnt_reg <= cnt_next;
    end
  end

  assign carry_cnt = cnt_reg;
`else
  assign carry_cnt = '0;
`endif

endmodule

// File: tb/tb_half_adder_sync.sv
// Directed self-checking bench for half_adder_sync (1-lane, 4-lane and 3-bit-counter instances).
`timescale 1ns/1ps
module tb_half_adder_sync;

`ifdef HALF_ADDER_CARRY_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk;
  logic        clk_en;
  logic        rst;
  logic        in_valid;
  logic [3:0]  a;
  logic [3:0]  b;

  logic        s1, c1, s1_q, c1_q, ov1;
  logic [15:0] cnt1;
  logic [3:0]  s4, c4, s4_q, c4_q;
  logic        ov4;
  logic [15:0] cnt4;
  logic [3:0]  s3, c3, s3_q, c3_q;
  logic        ov3;
  logic [2:0]  cnt3;

  int checks = 0;
  int errors = 0;

  half_adder_sync #(.WIDTH(1), .CNT_W(16)) dut1 (
    .clk(clk), .rst(rst), .a(a[0]), .b(b[0]), .in_valid(in_valid),
    .S(s1), .C(c1), .S_q(s1_q), .C_q(c1_q), .out_valid(ov1), .carry_cnt(cnt1)
  );

  half_adder_sync #(.WIDTH(4), .CNT_W(16)) dut4 (
    .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid),
    .S(s4), .C(c4), .S_q(s4_q), .C_q(c4_q), .out_valid(ov4), .carry_cnt(cnt4)
  );

  half_adder_sync #(.WIDTH(4), .CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .a(a), .b(b), .in_valid(in_valid),
    .S(s3), .C(c3), .S_q(s3_q), .C_q(c3_q), .out_valid(ov3), .carry_cnt(cnt3)
  );

  initial begin
    clk = 1'b0;
    wait (clk_en);
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    clk_en   = 1'b0;
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = 4'h0;
    b        = 4'h0;

    // Combinational truth table before any clock edge
    a = 4'h0; b = 4'h0; #10;
    chk("comb00_S", 32'(s1), 32'd0); chk("comb00_C", 32'(c1), 32'd0);
    a = 4'h0; b = 4'h1; #10;
    chk("comb01_S", 32'(s1), 32'd1); chk("comb01_C", 32'(c1), 32'd0);
    a = 4'h1; b = 4'h0; #10;
    chk("comb10_S", 32'(s1), 32'd1); chk("comb10_C", 32'(c1), 32'd0);
    a = 4'h1; b = 4'h1; #10;
    chk("comb11_S", 32'(s1), 32'd0); chk("comb11_C", 32'(c1), 32'd1);
    a = 4'b1100; b = 4'b1010; #1;
    chk("comb4_S", 32'(s4), 32'h6); chk("comb4_C", 32'(c4), 32'h8);
    $display("step comb: a=%b b=%b S=%b C=%b", a, b, s4, c4);

    // Reset held two cycles, then released with in_valid low
    clk_en = 1'b1;
    step();
    step();
    chk("rst_Sq", 32'(s4_q), 32'h0); chk("rst_Cq", 32'(c4_q), 32'h0);
    chk("rst_ov", 32'(ov4), 32'd0);  chk("rst_cnt", 32'(cnt4), 32'd0);
    rst = 1'b0;
    step();
    chk("post_rst_ov", 32'(ov4), 32'd0); chk("post_rst_Sq", 32'(s4_q), 32'h0);
    chk("post_rst_cnt", 32'(cnt4), 32'd0);
    $display("step reset: S_q=%h C_q=%h out_valid=%b cnt=%0d", s4_q, c4_q, ov4, cnt4);

    // Single valid 4-lane transaction
    in_valid = 1'b1; a = 4'b1100; b = 4'b1010;
    step();
    chk("v1_Sq", 32'(s4_q), 32'h6); chk("v1_Cq", 32'(c4_q), 32'h8);
    chk("v1_ov", 32'(ov4), 32'd1);
    chk("v1_cnt", 32'(cnt4), CNT_EN ? 32'd1 : 32'd0);
    $display("step valid: a=%b b=%b S_q=%b C_q=%b out_valid=%b", a, b, s4_q, c4_q, ov4);

    // Idle cycles: combinational follows inputs, registers hold
    in_valid = 1'b0; a = 4'h3; b = 4'h5; #1;
    chk("idle_S", 32'(s4), 32'h6); chk("idle_C", 32'(c4), 32'h1);
    step();
    chk("idle_Sq", 32'(s4_q), 32'h6); chk("idle_Cq", 32'(c4_q), 32'h8);
    chk("idle_ov", 32'(ov4), 32'd0);
    a = 4'hF; b = 4'h0; #1;
    chk("idle2_S", 32'(s4), 32'hF); chk("idle2_C", 32'(c4), 32'h0);
    step();
    chk("idle2_Cq", 32'(c4_q), 32'h8);
    chk("idle_cnt", 32'(cnt4), CNT_EN ? 32'd1 : 32'd0);
    $display("step idle: S=%b C=%b S_q=%b C_q=%b out_valid=%b", s4, c4, s4_q, c4_q, ov4);

    // Fresh reset, then three all-carry cycles: 4, 8, 12 (3-bit counter clamps at 7)
    rst = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b1; a = 4'hF; b = 4'hF;
    step();
    chk("cc1_cnt", 32'(cnt4), CNT_EN ? 32'd4 : 32'd0);
    chk("cc1_sat", 32'(cnt3), CNT_EN ? 32'd4 : 32'd0);
    step();
    chk("cc2_cnt", 32'(cnt4), CNT_EN ? 32'd8 : 32'd0);
    chk("cc2_sat", 32'(cnt3), CNT_EN ? 32'd7 : 32'd0);
    step();
    chk("cc3_cnt", 32'(cnt4), CNT_EN ? 32'd12 : 32'd0);
    chk("cc3_sat", 32'(cnt3), CNT_EN ? 32'd7 : 32'd0);
    chk("cc3_Sq", 32'(s4_q), 32'h0); chk("cc3_Cq", 32'(c4_q), 32'hF);
    chk("cc3_ov", 32'(ov4), 32'd1);
    $display("step carry: cnt=%0d sat_cnt=%0d C_q=%b", cnt4, cnt3, c4_q);

    // Reset wins over in_valid in the same cycle
    rst = 1'b1; in_valid = 1'b1; a = 4'hF; b = 4'hF;
    step();
    chk("rv_Cq", 32'(c4_q), 32'h0); chk("rv_ov", 32'(ov4), 32'd0);
    chk("rv_cnt", 32'(cnt4), 32'd0); chk("rv_sat", 32'(cnt3), 32'd0);
    chk("rv_Cq1", 32'(c1_q), 32'd0); chk("rv_ov1", 32'(ov1), 32'd0);
    $display("step rst+valid: C_q=%b out_valid=%b cnt=%0d", c4_q, ov4, cnt4);

    // Resume after mid-stream reset, then back-to-back valid cycles
    rst = 1'b0; a = 4'h5; b = 4'h3;
    step();
    chk("bb1_Sq", 32'(s4_q), 32'h6); chk("bb1_Cq", 32'(c4_q), 32'h1);
    chk("bb1_ov", 32'(ov4), 32'd1);
    a = 4'hF; b = 4'h1;
    step();
    chk("bb2_Sq", 32'(s4_q), 32'hE); chk("bb2_Cq", 32'(c4_q), 32'h1);
    chk("bb2_ov", 32'(ov4), 32'd1);
    chk("bb2_cnt", 32'(cnt4), CNT_EN ? 32'd2 : 32'd0);
    chk("bb2_Sq1", 32'(s1_q), 32'd0); chk("bb2_Cq1", 32'(c1_q), 32'd1);
    $display("step b2b: S_q=%b C_q=%b out_valid=%b cnt=%0d", s4_q, c4_q, ov4, cnt4);
    in_valid = 1'b0;
    step();
    chk("end_ov", 32'(ov4), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
